snoop_sequencer: RTL and testbench

SNOOP_SEQUENCER -- requirements
Module: snoop_sequencer

---
 rtl/snoop_sequencer.sv | 112 +++++++++++
 tb/tb_snoop_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_sequencer.sv
// Snoop sequencer: queues coherence instructions in a small FIFO and walks each one through
// four broadcast steps, advancing only on step_en pulses.
module snoop_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [8:0] in_instr,
  output logic       in_ready,
  input  logic       step_en,
  output logic [8:0] instruction,
  output logic [1:0] step,
  output logic       active,
  output logic       done,
  output logic [7:0] issued_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {StIdle, StS0, StS1, StS2, StS3} state_e;

  state_e            state_q;
  logic [8:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push, issue, fifo_empty;

  // Full blocks pushes even when a pop lands on the same edge.
  assign in_ready   = (count_q < CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && in_ready;
  assign issue      = step_en && !fifo_empty && ((state_q == StIdle) || (state_q == StS3));

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_instr;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, issue})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      step         <= 2'd0;
      active       <= 1'b0;
      instruction  <= '0;
      done         <= 1'b0;
      issued_count <= '0;
    end else begin
      done <= 1'b0;
      if (step_en) begin
        unique case (state_q)
          StIdle: begin
            if (!fifo_empty) begin
              state_q     <= StS0;
              step        <= 2'd0;
              active      <= 1'b1;
              instruction <= mem_q[rd_ptr_q];
            end
          end
          StS0: begin
            state_q <= StS1;
            step    <= 2'd1;
          end
          StS1: begin
            state_q <= StS2;
            step    <= 2'd2;
          end
          StS2: begin
            state_q <= StS3;
            step    <= 2'd3;
          end
          StS3: begin
            done         <= 1'b1;
            issued_count <= issued_count + 8'd1;
            step         <= 2'd0;
            // Chain straight into the next queued instruction without an idle bubble.
            if (!fifo_empty) begin
              state_q     <= StS0;
              active      <= 1'b1;
              instruction <= mem_q[rd_ptr_q];
            end else begin
              state_q <= StIdle;
              active  <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            step    <= 2'd0;
            active  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snoop_sequencer.sv
// Directed self-checking bench for snoop_sequencer (DEPTH = 4).
module tb_snoop_sequencer;

  logic       clock = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;
  logic       step_en;
  logic [8:0] instruction;
  logic [1:0] step;
  logic       active;
  logic       done;
  logic [7:0] issued_count;

  int checks   = 0;
  int failures = 0;

  snoop_sequencer #(.DEPTH(4)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .step_en     (step_en),
    .instruction (instruction),
    .step        (step),
    .active      (active),
    .done        (done),
    .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [8:0] vals  [4];
  logic [8:0] tail  [4];
  int         dcnt;
  int         n;
  int         waited;

  initial begin
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    step_en  = 1'b0;
    #12;
    chk("rst_active", active, 0);
    chk("rst_step", step, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_done", done, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_ready", in_ready, 1);

    // Single instruction, step_en held high.
    @(negedge clock);
    resetn   = 1'b1;
    in_valid = 1'b1;
    in_instr = 9'h1A5;
    step_en  = 1'b1;
    tick();
    chk("push_no_issue_same_cycle", active, 0);
    in_valid = 1'b0;
    tick();
    chk("s0_active", active, 1);
    chk("s0_step", step, 0);
    chk("s0_instr", instruction, 9'h1A5);
    for (int s = 1; s < 4; s++) begin
      tick();
      chk("walk_step", step, s);
      chk("walk_instr", instruction, 9'h1A5);
      chk("walk_done", done, 0);
    end
    tick();
    chk("end_done", done, 1);
    chk("end_active", active, 0);
    chk("end_issued", issued_count, 1);
    chk("idle_instr_hold", instruction, 9'h1A5);
    tick();
    chk("done_one_cycle", done, 0);

    // Fill the FIFO, reject a fifth offer, then drain back-to-back.
    vals[0] = 9'h001; vals[1] = 9'h0F2; vals[2] = 9'h153; vals[3] = 9'h1E4;
    step_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = vals[i];
      tick();
      chk("fill_ready", in_ready, (i < 3) ? 1 : 0);
    end
    in_instr = 9'h0AA;
    tick();
    chk("full_ready", in_ready, 0);
    chk("stalled_idle", active, 0);
    in_valid = 1'b0;
    step_en  = 1'b1;
    dcnt     = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("drain_step", step, k % 4);
      chk("drain_instr", instruction, vals[k / 4]);
      chk("drain_active", active, 1);
      if (done) dcnt++;
    end
    tick();
    if (done) dcnt++;
    chk("drain_done_pulses", dcnt, 4);
    chk("drain_issued", issued_count, 5);
    chk("drain_idle", active, 0);
    tick();
    chk("rejected_not_queued", active, 0);

    // Stall in the middle of an instruction.
    step_en  = 1'b0;
    in_valid = 1'b1;
    in_instr = 9'h055;
    tick();
    in_valid = 1'b0;
    step_en  = 1'b1;
    tick();
    tick();
    chk("stall_s1", step, 1);
    tick();
    chk("stall_s2", step, 2);
    step_en = 1'b0;
    tick();
    chk("stall_hold1", step, 2);
    tick();
    chk("stall_hold2", step, 2);
    chk("stall_instr", instruction, 9'h055);
    chk("stall_no_done", done, 0);
    step_en = 1'b1;
    tick();
    chk("stall_s3", step, 3);
    tick();
    chk("stall_done", done, 1);
    chk("stall_issued", issued_count, 6);

    // FIFO full while in S3: pop happens, push rejected, accepted next cycle.
    step_en  = 1'b0;
    in_valid = 1'b1;
    in_instr = 9'h077;
    tick();
    in_valid = 1'b0;
    step_en  = 1'b1;
    tick();
    chk("x_s0", instruction, 9'h077);
    step_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = 9'h101 + 9'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("x_full", in_ready, 0);
    step_en = 1'b1;
    repeat (3) tick();
    chk("x_s3", step, 3);
    in_valid = 1'b1;
    in_instr = 9'h1FF;
    chk("x_ready_in_s3", in_ready, 0);
    tick();
    chk("x_pop_step", step, 0);
    chk("x_pop_instr", instruction, 9'h101);
    chk("x_pop_done", done, 1);
    chk("x_issued", issued_count, 7);
    chk("x_ready_after_pop", in_ready, 1);
    step_en = 1'b0;
    tick();
    chk("x_push_accepted", in_ready, 0);
    in_valid = 1'b0;
    step_en  = 1'b1;
    tail[0] = 9'h102; tail[1] = 9'h103; tail[2] = 9'h104; tail[3] = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      repeat (4) tick();
      chk("x_order", instruction, tail[i]);
    end
    repeat (4) tick();
    chk("x_final_idle", active, 0);
    chk("x_final_issued", issued_count, 12);

    // Asynchronous reset during S2 with entries queued.
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_instr = 9'h011 * 9'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    step_en  = 1'b1;
    repeat (3) tick();
    chk("r_s2", step, 2);
    step_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("r_active", active, 0);
    chk("r_step", step, 0);
    chk("r_ready", in_ready, 1);
    chk("r_issued", issued_count, 0);
    chk("r_instr", instruction, 0);
    tick();
    chk("r_no_done", done, 0);
    @(negedge clock);
    resetn   = 1'b1;
    in_valid = 1'b1;
    in_instr = 9'h0C3;
    step_en  = 1'b1;
    tick();
    chk("r_queue_flushed", active, 0);
    in_valid = 1'b0;
    tick();
    chk("r_new_s0", active, 1);
    chk("r_new_instr", instruction, 9'h0C3);
    repeat (3) tick();
    chk("r_new_s3", step, 3);
    tick();
    chk("r_new_done", done, 1);
    chk("r_new_issued", issued_count, 1);
    tick();
    chk("r_new_idle", active, 0);

    // issued_count wrap: 255 more completions bring it from 1 to 0.
    step_en  = 1'b1;
    in_valid = 1'b1;
    n        = 0;
    for (int c = 0; c < 3000 && n < 255; c++) begin
      in_instr = 9'(c);
      tick();
      if (done) begin
        n++;
        if (n == 254) chk("wrap_255", issued_count, 255);
        if (n == 255) chk("wrap_0", issued_count, 0);
      end
    end
    chk("wrap_completions", n, 255);
    in_valid = 1'b0;
    waited   = 0;
    while (active && waited < 100) begin
      tick();
      waited++;
    end
    chk("final_drain_idle", active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
